// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } seq_state_t;

    // A dimension of 1 still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with a wrapping accumulator; clr wins over en.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequences one shared MAC over every C[i][j] = sum_k A[i][k]*B[k][j],
// reading operands from synchronous RAMs and streaming results out.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int J      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              a_rd_en,
    output logic [clog2_min1(M*K)-1:0]        a_addr,
    input  logic [DATA_W-1:0]                 a_data,
    output logic                              b_rd_en,
    output logic [clog2_min1(K*J)-1:0]        b_addr,
    input  logic [DATA_W-1:0]                 b_data,
    output logic                              c_valid,
    input  logic                              c_ready,
    output logic [ACC_W-1:0]                  c_data,
    output logic [clog2_min1(M)-1:0]          c_row,
    output logic [clog2_min1(J)-1:0]          c_col
);

    localparam int IW = clog2_min1(M);
    localparam int JW = clog2_min1(J);
    localparam int KW = clog2_min1(K);
    localparam int AW = clog2_min1(M*K);
    localparam int BW = clog2_min1(K*J);

    seq_state_t state, state_nxt;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          rd, clr, last_k, last_ij, xfer;
    logic          vld_q;
    logic [1:0]    vld_pipe;

    assign rd      = (state == RUN);
    assign last_k  = (k == KW'(K-1));
    assign last_ij = (i == IW'(M-1)) && (j == JW'(J-1));
    assign xfer    = (state == OUT) && c_ready;

    // Read strobe in [0]; the cycle its data returns in [1].
    assign vld_pipe = {vld_q, rd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_q <= 1'b0;
        else
            vld_q <= vld_pipe[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            IDLE:  if (start) begin
                       state_nxt = RUN;
                       clr       = 1'b1;
                   end
            RUN:   if (last_k) state_nxt = DRAIN;
            DRAIN: state_nxt = OUT;
            OUT:   if (c_ready) begin
                       if (last_ij) begin
                           state_nxt = DONE;
                       end else begin
                           state_nxt = RUN;
                           clr       = 1'b1;
                       end
                   end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                          i <= '0;
                          j <= '0;
                          k <= '0;
                      end
                RUN:  k <= last_k ? '0 : k + 1'b1;
                OUT:  if (xfer && !last_ij) begin
                          k <= '0;
                          if (j == JW'(J-1)) begin
                              j <= '0;
                              i <= i + 1'b1;
                          end else begin
                              j <= j + 1'b1;
                          end
                      end
                DONE: begin
                          i <= '0;
                          j <= '0;
                      end
                default: ;
            endcase
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (vld_pipe[1]),
        .a     (a_data),
        .b     (b_data),
        .acc   (c_data)
    );

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign c_valid = (state == OUT);
    assign c_row   = i;
    assign c_col   = j;
    assign a_rd_en = rd;
    assign b_rd_en = rd;
    assign a_addr  = rd ? AW'(int'(i) * K + int'(k)) : '0;
    assign b_addr  = rd ? BW'(int'(k) * J + int'(j)) : '0;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench: identity, backpressure, reset, stray start on a 2x2x2 instance,
// plus signed and wrap-around cases on two small instances.
module tb_matmul_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---- instance 0: M=K=J=2, identity B
    logic        start0, busy0, done0, a_rd_en0, b_rd_en0, c_valid0, c_ready0;
    logic [1:0]  a_addr0, b_addr0;
    logic [7:0]  a_data0, b_data0;
    logic [31:0] c_data0;
    logic [0:0]  c_row0, c_col0;
    logic [7:0]  amem0 [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0]  bmem0 [4] = '{8'd1, 8'd0, 8'd0, 8'd1};

    matmul_seq #(.M(2), .K(2), .J(2), .DATA_W(8), .ACC_W(32)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .a_rd_en(a_rd_en0), .a_addr(a_addr0), .a_data(a_data0),
        .b_rd_en(b_rd_en0), .b_addr(b_addr0), .b_data(b_data0),
        .c_valid(c_valid0), .c_ready(c_ready0), .c_data(c_data0),
        .c_row(c_row0), .c_col(c_col0)
    );

    always_ff @(posedge clk) begin
        if (a_rd_en0) a_data0 <= amem0[a_addr0];
        if (b_rd_en0) b_data0 <= bmem0[b_addr0];
    end

    // ---- instance 1: M=1, K=2, J=1, signed operands
    logic        start1, busy1, done1, a_rd_en1, b_rd_en1, c_valid1;
    logic        c_ready1 = 1'b1;
    logic [0:0]  a_addr1, b_addr1, c_row1, c_col1;
    logic [7:0]  a_data1, b_data1;
    logic [31:0] c_data1;
    logic [7:0]  amem1 [2] = '{8'hFD, 8'h05};
    logic [7:0]  bmem1 [2] = '{8'h02, 8'hFC};

    matmul_seq #(.M(1), .K(2), .J(1), .DATA_W(8), .ACC_W(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .a_rd_en(a_rd_en1), .a_addr(a_addr1), .a_data(a_data1),
        .b_rd_en(b_rd_en1), .b_addr(b_addr1), .b_data(b_data1),
        .c_valid(c_valid1), .c_ready(c_ready1), .c_data(c_data1),
        .c_row(c_row1), .c_col(c_col1)
    );

    always_ff @(posedge clk) begin
        if (a_rd_en1) a_data1 <= amem1[a_addr1];
        if (b_rd_en1) b_data1 <= bmem1[b_addr1];
    end

    // ---- instance 2: M=J=1, K=4, 16-bit accumulator, all operands -128
    logic        start2, busy2, done2, a_rd_en2, b_rd_en2, c_valid2;
    logic        c_ready2 = 1'b1;
    logic [1:0]  a_addr2, b_addr2;
    logic [0:0]  c_row2, c_col2;
    logic [7:0]  a_data2, b_data2;
    logic [15:0] c_data2;

    matmul_seq #(.M(1), .K(4), .J(1), .DATA_W(8), .ACC_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .a_rd_en(a_rd_en2), .a_addr(a_addr2), .a_data(a_data2),
        .b_rd_en(b_rd_en2), .b_addr(b_addr2), .b_data(b_data2),
        .c_valid(c_valid2), .c_ready(c_ready2), .c_data(c_data2),
        .c_row(c_row2), .c_col(c_col2)
    );

    always_ff @(posedge clk) begin
        if (a_rd_en2) a_data2 <= 8'h80;
        if (b_rd_en2) b_data2 <= 8'h80;
    end

    // One full multiply on instance 0. Cycle 1 is the cycle after the start edge.
    // hold: stall cycles on the first result; stray: extra starts in OUT and DRAIN;
    // rst_elem: assert reset while reading for that element index (-1 = never).
    task automatic run0(input int hold, input bit stray, input int rst_elem,
                        output int done_cyc);
        int cyc, elem, kc, held;
        bit s_out, s_drain;
        logic [31:0] held_data;
        int cexp [4] = '{1, 2, 3, 4};
        done_cyc = -1; elem = 0; kc = 0; held = 0; s_out = 0; s_drain = 0;
        held_data = '0;
        @(negedge clk);
        start0   = 1'b1;
        c_ready0 = (hold == 0);
        @(negedge clk);
        cyc = 1;
        while (cyc < 100 && done_cyc < 0) begin
            start0 = 1'b0;
            if (a_rd_en0) begin
                chk("a_addr", a_addr0, (elem / 2) * 2 + kc);
                chk("b_addr", b_addr0, kc * 2 + elem % 2);
                kc++;
                if (elem == rst_elem) begin
                    reset = 1'b1;
                    @(negedge clk);
                    chk("rst_busy", busy0, 0);
                    chk("rst_done", done0, 0);
                    chk("rst_rd", {a_rd_en0, b_rd_en0}, 0);
                    chk("rst_addr", {a_addr0, b_addr0}, 0);
                    chk("rst_valid", c_valid0, 0);
                    chk("rst_data", c_data0, 0);
                    chk("rst_rowcol", {c_row0, c_col0}, 0);
                    reset = 1'b0;
                    done_cyc = -2;
                    return;
                end
            end
            if (c_valid0) begin
                if (elem == 0 && held < hold) begin
                    if (held == 0) held_data = c_data0;
                    else chk("bp_stable", c_data0, held_data);
                    chk("bp_no_read", a_rd_en0, 0);
                    held++;
                    c_ready0 = 1'b0;
                end else begin
                    c_ready0 = 1'b1;
                    chk("c_row", c_row0, elem / 2);
                    chk("c_col", c_col0, elem % 2);
                    chk("c_data", c_data0, cexp[elem]);
                    elem++;
                    kc = 0;
                    if (stray && !s_out) begin
                        start0 = 1'b1;
                        s_out  = 1'b1;
                    end
                end
            end
            if (stray && !s_drain && busy0 && !a_rd_en0 && !c_valid0 && !done0) begin
                start0  = 1'b1;
                s_drain = 1'b1;
            end
            if (done0) begin
                done_cyc = cyc;
                chk("n_results", elem, 4);
            end
            @(negedge clk);
            cyc++;
        end
        start0   = 1'b0;
        c_ready0 = 1'b1;
    endtask

    initial begin
        int dc, cyc, n1, n2, dc1, dc2;
        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        c_ready0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst0_busy", busy0, 0);
        chk("rst0_valid", c_valid0, 0);
        chk("rst0_done", done0, 0);
        chk("rst0_data", c_data0, 0);
        chk("rst0_rd", a_rd_en0, 0);
        chk("rst1_busy", busy1, 0);
        reset = 1'b0;

        run0(0, 1'b0, -1, dc);
        chk("id_done_cyc", dc, 17);
        @(negedge clk);
        chk("done_pulse", done0, 0);
        chk("idle_busy", busy0, 0);

        run0(5, 1'b0, -1, dc);
        chk("bp_done_cyc", dc, 22);

        run0(0, 1'b1, -1, dc);
        chk("stray_done_cyc", dc, 17);

        run0(0, 1'b0, 2, dc);
        chk("rst_aborted", dc, -2);
        run0(0, 1'b0, -1, dc);
        chk("rerun_done_cyc", dc, 17);

        // Instances 1 and 2 run together with c_ready tied high.
        @(negedge clk);
        start1 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        cyc = 1; n1 = 0; n2 = 0; dc1 = -1; dc2 = -1;
        while (cyc < 40 && (dc1 < 0 || dc2 < 0)) begin
            if (c_valid1) begin
                chk("sgn_data", $signed(c_data1), -26);
                chk("sgn_raw", c_data1, 32'hFFFF_FFE6);
                n1++;
            end
            if (c_valid2) begin
                chk("wrap_data", c_data2, 0);
                n2++;
            end
            if (done1 && dc1 < 0) dc1 = cyc;
            if (done2 && dc2 < 0) dc2 = cyc;
            @(negedge clk);
            cyc++;
        end
        chk("sgn_done_cyc", dc1, 5);
        chk("wrap_done_cyc", dc2, 7);
        chk("sgn_count", n1, 1);
        chk("wrap_count", n2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Sequencer that computes C = A × B by driving one shared multiply-accumulate datapath across every (row, column) output element. It reads A and B element-by-element from external synchronous-read memories, walks the inner dimension, and streams each finished C element out over a valid/ready handshake. It is the control layer between the operand RAMs and the downstream result sink of the matmul datapath.

## Interface
- `M`, default 4: rows of A and C.
- `K`, default 4: inner dimension (cols of A, rows of B); must be ≥ 1.
- `J`, default 4: cols of B and C.
- `DATA_W`, default 8: signed operand width.
- `ACC_W`, default 32: signed accumulator and result width; must be ≥ 2·DATA_W.

- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high; returns the block to IDLE.
- `start` in 1: single-cycle request to begin a multiply; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last C element is accepted.
- `a_rd_en` out 1: read strobe to the A RAM.
- `a_addr` out clog2(M·K): row-major, i·K + k.
- `a_data` in DATA_W: A RAM read data; valid one cycle after `a_rd_en`.
- `b_rd_en` out 1: read strobe to the B RAM.
- `b_addr` out clog2(K·J): row-major, k·J + j.
- `b_data` in DATA_W: B RAM read data; valid one cycle after `b_rd_en`.
- `c_valid` out 1: result valid.
- `c_ready` in 1: sink ready.
- `c_data` out ACC_W: C[i][j].
- `c_row` out clog2(M): i of the presented result.
- `c_col` out clog2(J): j of the presented result.

## Operation
- **States:**
  - IDLE: `start` → RUN with i = j = k = 0 and the accumulator cleared.
  - RUN: each cycle asserts `a_rd_en`/`b_rd_en` with addresses for the current (i, j, k), then increments k. After issuing k = K−1, goes to DRAIN.
  - DRAIN: one cycle to absorb the last product.
  - OUT: drives `c_valid` = 1 with `c_data`/`c_row`/`c_col`. On `c_valid & c_ready`:
    - if (i, j) = (M−1, J−1): go to DONE;
    - otherwise advance j (on j wrap to 0, increment i), set k = 0, clear the accumulator, and go to RUN.
  - DONE: `done` = 1 for exactly one cycle, then IDLE.
- **Accumulate:**
  - Whenever the read issued in the previous cycle returns, acc += sign_ext(a_data × b_data).
  - The product is a full 2·DATA_W signed value.
  - The sum wraps modulo 2^ACC_W; there is no saturation and no overflow flag.
- **OUT behaviour:**
  - `c_data` equals the accumulator and is held stable while `c_valid & !c_ready`.
  - No reads are issued in OUT; backpressure stalls the whole sequence.
- **`start` handling:** `start` outside IDLE is ignored; no restart and no queuing.
- **Reset:** `reset` asserted at any time, including mid-matrix or mid-handshake, immediately forces IDLE. Partial results are discarded.
- **Reset values:** all outputs 0; counters and accumulator 0.
- **Read enables:** `a_rd_en` and `b_rd_en` are high only in RUN. Addresses are 0 outside RUN.

## Timing
- **Handshake:** `c_valid` may rise in a cycle where `c_ready` is already high; the transfer completes in that cycle.
- **Per-element cost:** K + 2 cycles minimum (K RUN, 1 DRAIN, 1 OUT).
- **Start to first result:** the `start` edge → first `c_valid` at cycle K + 2 after that edge.
- **Total latency:** with `c_ready` tied high, `done` is high in cycle M·J·(K+2) + 1 after the `start` edge.
- **Back-to-back:** `start` can be accepted in the cycle after `done`.
- **Read timing:** RAM data is consumed exactly one cycle after its strobe. No other read latency is supported.
- **K = 1:** RUN lasts a single cycle.

## Structure
- **`matmul_pkg`:** shared package holding the state enum `seq_state_t` (IDLE, RUN, DRAIN, OUT, DONE) and a `clog2_min1` helper for index widths, so that a dimension of 1 still yields a 1-bit index.
- **`mac_unit`:** one sub-module.
  - Ports: `clk`, `reset`, `clr`, `en`, `a`, `b`, `acc`.
  - Behaviour: signed multiply, sign-extend, wrap-add.
  - Priority: `clr` has priority over `en`.
- **`matmul_seq`:** holds the FSM, the i/j/k counters, and the address generation.

## Test plan
- **Identity:** M = K = J = 2, A = [[1,2],[3,4]], B = I, `c_ready` = 1.
  - Outputs in order (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4.
  - `done` in cycle 17.
- **Signed:** A = [[−3,5]], B = [[2],[−4]] (M = 1, K = 2, J = 1). Output −26 (0xFFFFFFE6).
- **Wrap:** ACC_W = 16, DATA_W = 8, K = 4, all operands −128. Each product is 16384; the sum 65536 wraps to C = 0.
- **Backpressure:** hold `c_ready` = 0 for 5 cycles on the first result.
  - `c_data` is stable and no `a_rd_en` occurs during the hold.
  - The total `done` time grows by exactly 5.
- **Reset mid-run:** assert `reset` during RUN of element (1,0).
  - Next cycle: `busy` = 0 and all outputs are 0.
  - A fresh `start` reproduces the full correct result.
- **`start` while busy:** pulse `start` during OUT and again during DRAIN. Element order, values and `done` timing are unchanged from a single-`start` run.
